// File: rtl/gpio_banked_pkg.sv
// gpio_banked_pkg: shared definitions for the banked APB GPIO controller.
// Contents: per-bank register offsets, the 2-bit interrupt type encoding and
// the bank-count helper used to size per-bank storage.
package gpio_banked_pkg;

    // Register offsets within a 64-byte bank window.
    localparam logic [5:0] OFF_DIR       = 6'h00;
    localparam logic [5:0] OFF_IN        = 6'h04;
    localparam logic [5:0] OFF_OUT       = 6'h08;
    localparam logic [5:0] OFF_OUT_SET   = 6'h0C;
    localparam logic [5:0] OFF_OUT_CLR   = 6'h10;
    localparam logic [5:0] OFF_INTEN     = 6'h14;
    localparam logic [5:0] OFF_INTTYPE0  = 6'h18;
    localparam logic [5:0] OFF_INTTYPE1  = 6'h1C;
    localparam logic [5:0] OFF_INTSTATUS = 6'h20;
    localparam logic [5:0] OFF_DEBOUNCE  = 6'h24;

    // Interrupt type, encoded as {INTTYPE1[i], INTTYPE0[i]}.
    typedef enum logic [1:0] {
        IrqRise  = 2'b00,
        IrqFall  = 2'b01,
        IrqBoth  = 2'b10,
        IrqLevel = 2'b11
    } irq_type_e;

    // Number of 32-pin banks needed for a given pad count.
    function automatic int unsigned bank_count(input int unsigned pads);
        return (pads + 31) / 32;
    endfunction

endpackage

// File: rtl/apb_gpio_banked_if.sv
// apb_gpio_banked_if: APB3 slave bundle for the banked GPIO controller.
// Signals: paddr/pwdata/pwrite/psel/penable (master -> slave),
//          prdata/pready/pslverr (slave -> master).
interface apb_gpio_banked_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [31:0]               pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [31:0]               prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: per-pin input conditioning.
// SYNC_STAGES-deep synchroniser, then (with GPIO_DEBOUNCE_EN defined) a
// DEBOUNCE_W-bit debounce counter; otherwise the synchroniser output is used
// directly. Produces the filtered value and its one-cycle-delayed copy.
// Ports: clk, rst_n (async active-low), pad_in (raw pad), threshold
//        (debounce threshold), filt (filtered value), filt_q (filt delayed).
module gpio_pin_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pad_in,
    input  logic [DEBOUNCE_W-1:0] threshold,
    output logic                  filt,
    output logic                  filt_q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] cnt_q;
    logic                  filt_r;

    // Counter runs only while the synced input disagrees with the filtered
    // value; the new value is accepted once it reaches the threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_r <= 1'b0;
        end else if (synced != filt_r) begin
            if (cnt_q == threshold) begin
                filt_r <= synced;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + DEBOUNCE_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign filt = filt_r;
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
    assign filt = synced;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) filt_q <= 1'b0;
        else        filt_q <= filt;
    end

endmodule

// File: rtl/apb_gpio_banked.sv
// apb_gpio_banked: parametrised APB GPIO controller, 32 pins per bank.
// Per bank: DIR, IN, OUT, OUT_SET, OUT_CLR, INTEN, INTTYPE0/1, INTSTATUS
// (W1C), DEBOUNCE. Optional debounce when GPIO_DEBOUNCE_EN is defined.
// Ports: sys_clk_i, sys_rst_ni (async active-low); apb (APB slave modport);
//        gpio_in_i (raw pads), gpio_out_o, gpio_oe_o, gpio_in_sync_o
//        (filtered input), interrupt_o (level), gpio_event_o (per-bank pulse).
module apb_gpio_banked
    import gpio_banked_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned PAD_NUM        = 64,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_W     = 8
) (
    input  logic                           sys_clk_i,
    input  logic                           sys_rst_ni,
    apb_gpio_banked_if.slave               apb,
    input  logic [PAD_NUM-1:0]             gpio_in_i,
    output logic [PAD_NUM-1:0]             gpio_out_o,
    output logic [PAD_NUM-1:0]             gpio_oe_o,
    output logic [PAD_NUM-1:0]             gpio_in_sync_o,
    output logic                           interrupt_o,
    output logic [bank_count(PAD_NUM)-1:0] gpio_event_o
);

    localparam int unsigned NB = bank_count(PAD_NUM);
    localparam int unsigned NP = NB * 32;
    // Ones for implemented pins; padding pins in the last bank stay 0.
    localparam logic [NP-1:0] PIN_MASK = {NP{1'b1}} >> (NP - PAD_NUM);

    logic [NP-1:0] dir_q, dir_d, out_q, out_d, inten_q, inten_d;
    logic [NP-1:0] type0_q, type0_d, type1_q, type1_d, status_q, status_d;
    logic [NP-1:0] filt, filt_q, hit, set, w1c;
    logic [NB-1:0] new_bank, new_q, event_q;
    logic          irq_q;

    logic          access, wr_en, rd_en, bank_ok, off_ok;
    logic [5:0]    off;
    int unsigned   bank_idx, bsel;
    logic [31:0]   wdata;

`ifdef GPIO_DEBOUNCE_EN
    logic [NB-1:0][DEBOUNCE_W-1:0] deb_q, deb_d;
`endif

    // Input conditioning, one filter per implemented pin.
    for (genvar i = 0; i < NP; i++) begin : g_pin
        if (i < PAD_NUM) begin : g_used
            logic [DEBOUNCE_W-1:0] thr;
`ifdef GPIO_DEBOUNCE_EN
            assign thr = deb_q[i/32];
`else
            assign thr = '0;
`endif
            gpio_pin_filter #(
                .SYNC_STAGES(SYNC_STAGES),
                .DEBOUNCE_W (DEBOUNCE_W)
            ) u_filter (
                .clk      (sys_clk_i),
                .rst_n    (sys_rst_ni),
                .pad_in   (gpio_in_i[i]),
                .threshold(thr),
                .filt     (filt[i]),
                .filt_q   (filt_q[i])
            );
        end else begin : g_pad
            assign filt[i]   = 1'b0;
            assign filt_q[i] = 1'b0;
        end
    end

    // APB decode.
    assign access   = apb.psel & apb.penable;
    assign off      = apb.paddr[5:0];
    assign bank_idx = 32'(apb.paddr[APB_ADDR_WIDTH-1:6]);
    assign bank_ok  = bank_idx < NB;
    assign off_ok   = off inside {OFF_DIR, OFF_IN, OFF_OUT, OFF_OUT_SET, OFF_OUT_CLR,
                                  OFF_INTEN, OFF_INTTYPE0, OFF_INTTYPE1, OFF_INTSTATUS,
                                  OFF_DEBOUNCE};
    assign bsel     = bank_ok ? bank_idx : 32'd0;
    assign wdata    = apb.pwdata & PIN_MASK[bsel*32 +: 32];
    assign wr_en    = access & apb.pwrite & bank_ok & off_ok;
    assign rd_en    = access & ~apb.pwrite & bank_ok & off_ok;

    assign apb.pready  = 1'b1;
    assign apb.pslverr = access & ~(bank_ok & off_ok);

    // Per-pin event detection by configured type.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NP; i++) begin
            case (irq_type_e'({type1_q[i], type0_q[i]}))
                IrqRise:  hit[i] = filt[i] & ~filt_q[i];
                IrqFall:  hit[i] = ~filt[i] & filt_q[i];
                IrqBoth:  hit[i] = filt[i] ^ filt_q[i];
                IrqLevel: hit[i] = filt[i];
            endcase
        end
    end

    assign set = hit & inten_q & PIN_MASK;

    always_comb begin
        dir_d   = dir_q;
        out_d   = out_q;
        inten_d = inten_q;
        type0_d = type0_q;
        type1_d = type1_q;
        w1c     = '0;
`ifdef GPIO_DEBOUNCE_EN
        deb_d   = deb_q;
`endif
        if (wr_en) begin
            case (off)
                OFF_DIR:       dir_d[bsel*32 +: 32]   = wdata;
                OFF_OUT:       out_d[bsel*32 +: 32]   = wdata;
                OFF_OUT_SET:   out_d[bsel*32 +: 32]   = out_q[bsel*32 +: 32] | wdata;
                OFF_OUT_CLR:   out_d[bsel*32 +: 32]   = out_q[bsel*32 +: 32] & ~wdata;
                OFF_INTEN:     inten_d[bsel*32 +: 32] = wdata;
                OFF_INTTYPE0:  type0_d[bsel*32 +: 32] = wdata;
                OFF_INTTYPE1:  type1_d[bsel*32 +: 32] = wdata;
                OFF_INTSTATUS: w1c[bsel*32 +: 32]     = wdata;
`ifdef GPIO_DEBOUNCE_EN
                OFF_DEBOUNCE:  deb_d[bsel]            = apb.pwdata[DEBOUNCE_W-1:0];
`endif
                default: ;
            endcase
        end
        // A new event wins over a simultaneous clear.
        status_d = (status_q & ~w1c) | set;
    end

    always_comb begin
        apb.prdata = '0;
        if (rd_en) begin
            case (off)
                OFF_DIR:       apb.prdata = dir_q[bsel*32 +: 32];
                OFF_IN:        apb.prdata = filt[bsel*32 +: 32];
                OFF_OUT:       apb.prdata = out_q[bsel*32 +: 32];
                OFF_INTEN:     apb.prdata = inten_q[bsel*32 +: 32];
                OFF_INTTYPE0:  apb.prdata = type0_q[bsel*32 +: 32];
                OFF_INTTYPE1:  apb.prdata = type1_q[bsel*32 +: 32];
                OFF_INTSTATUS: apb.prdata = status_q[bsel*32 +: 32];
`ifdef GPIO_DEBOUNCE_EN
                OFF_DEBOUNCE:  apb.prdata = 32'(deb_q[bsel]);
`endif
                default:       apb.prdata = '0;
            endcase
        end
    end

    // Bits going 0->1 this cycle, reduced per bank.
    always_comb begin
        new_bank = '0;
        for (int b = 0; b < NB; b++) begin
            new_bank[b] = |(set[b*32 +: 32] & ~status_q[b*32 +: 32]);
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            dir_q    <= '0;
            out_q    <= '0;
            inten_q  <= '0;
            type0_q  <= '0;
            type1_q  <= '0;
            status_q <= '0;
            new_q    <= '0;
            event_q  <= '0;
            irq_q    <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
            deb_q    <= '0;
`endif
        end else begin
            dir_q    <= dir_d;
            out_q    <= out_d;
            inten_q  <= inten_d;
            type0_q  <= type0_d;
            type1_q  <= type1_d;
            status_q <= status_d;
            new_q    <= new_bank;
            event_q  <= new_q;
            irq_q    <= |(status_q & inten_q);
`ifdef GPIO_DEBOUNCE_EN
            deb_q    <= deb_d;
`endif
        end
    end

    assign gpio_out_o     = out_q[PAD_NUM-1:0];
    assign gpio_oe_o      = dir_q[PAD_NUM-1:0];
    assign gpio_in_sync_o = filt[PAD_NUM-1:0];
    assign interrupt_o    = irq_q;
    assign gpio_event_o   = event_q;

endmodule
